uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- Parametrised UART receive framer clocked directly by the oversampling clock at OVERSAMPLE × baud.
- Supports configurable data width, oversampling ratio, parity mode and stop-bit count.
- Uses 3-sample majority voting at each bit centre, with a valid/ready output handshake and sticky error flags.
- Sits between the RX pin and the byte-level consumer; clock-domain crossing of its outputs is the consumer's job.

Parameters:
- DATA_BITS, 8: data bits per frame, legal 5..9, LSB first.
- OVERSAMPLE, 3: samples per bit, legal 3..16.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal 1 or 2.

Ports:
- rx_sampler_clk  in  1  oversampling clock.
- rx_sampler_reset  in  1  reset, asynchronous, active-low.
- rx_i  in  1  serial line, asynchronous to the clock.
- data_o  out  DATA_BITS  received word, valid while valid_o.
- valid_o  out  1  word available.
- ready_i  in  1  consumer accepts the word when valid_o && ready_i.
- err_o  out  3  sticky {overrun, parity, frame}.
- err_clr_i  in  1  clears all err_o bits.
- busy_o  out  1  frame in progress (state != IDLE).

Behaviour:
- Reset values: data_o = 0, valid_o = 0, err_o = 0, busy_o = 0; state = IDLE. Synchroniser flops reset to 1.
- Input synchroniser: rx_i passes through a 2-flop synchroniser; rxs denotes the second flop. All decisions use rxs.
- Sample counter: cnt runs 0..OVERSAMPLE-1 and wraps at the end of each bit period. mid = OVERSAMPLE/2.
- Bit vote: majority of rxs at cnt = mid-1, mid, mid+1, registered at cnt = mid+1.
- IDLE:
  - On rxs == 0: go to START with cnt = 1, so the detecting sample counts as index 0.
- START:
  - At the vote: if the voted bit is 1 (glitch), return to IDLE with no error.
  - Otherwise continue; at wrap go to DATA with bitno = 0.
- DATA:
  - At each vote, shift the voted bit in at the MSB (LSB-first line order).
  - At wrap with bitno == DATA_BITS-1: go to PARITY if PARITY != 0, else STOP.
- PARITY:
  - At the vote, compare against the XOR of the data bits.
  - Expected bit: odd mode makes total ones odd; even mode makes total ones even.
  - Mismatch sets a per-frame parity flag. At wrap go to STOP.
- STOP:
  - At the vote of each stop bit: voted 0 sets err_o[0] (frame error) and drops the word; go to IDLE immediately.
  - At the vote of the final stop bit when voted 1: go to IDLE immediately without waiting for wrap (early return allows resync).
  - At the same time, deliver the word, or record overrun per the output rules below.
  - With STOP_BITS = 2, the first stop bit is voted and checked, then the second.
- Word delivery:
  - Occurs on the edge at the final stop vote.
  - If valid_o is 0, or valid_o && ready_i in that same cycle: load data_o, set valid_o. Latency is 1 clock from the vote.
  - If the parity flag is set: the word is still delivered, and err_o[1] is set.
- Overrun: if valid_o && !ready_i at delivery, the new word is dropped, data_o is kept, and err_o[2] is set.
- Handshake: valid_o clears on valid_o && ready_i unless a new word loads in the same cycle, in which case valid_o stays 1 with the new data.
- Errors:
  - err_o bits stay set until err_clr_i.
  - If err_clr_i coincides with a new error event, the set wins.
- Reset mid-frame: returns to IDLE immediately, partial word discarded, no error flagged.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Enabled:
  - Adds output break_o (1 bit, reset 0).
  - Break is defined as a frame-error frame in which all data bits, the parity bit if present, and the stop bit are 0.
  - On break: set break_o, do not set err_o[0], and stay in a BREAK state until rxs == 1 for one full bit period (OVERSAMPLE consecutive samples), then go to IDLE.
  - break_o clears on err_clr_i.
- Disabled: no break_o port; an all-zero frame is an ordinary frame error.

Decomposition:
- Package uart_pkg holds:
  - the parity mode constants PAR_NONE / PAR_ODD / PAR_EVEN;
  - the state enum IDLE / START / DATA / PARITY / STOP / BREAK;
  - the err_o bit index constants ERR_FRAME = 0, ERR_PARITY = 1, ERR_OVERRUN = 2.
- Sub-module uart_majority3: a 3-sample shift register with a majority output. Reused later by the TX loopback checker.

Test Plan:
- Defaults, ready_i = 1: send 0x55 then 0xC3 with exact bit timing -> valid_o pulses once each, with data_o = 0x55 then 0xC3; err_o = 0.
- DATA_BITS = 7, PARITY = 2: send 0x2A with correct parity bit 1 -> data_o = 0x2A, err_o = 0. Resend with parity bit 0 -> data_o = 0x2A, err_o = 3'b010.
- Stop bit held 0 on 0xFF -> no valid_o, err_o = 3'b001; after err_clr_i, err_o = 0.
- ready_i = 0: send 0x81 then 0xA5 -> data_o stays 0x81, err_o = 3'b100. Raise ready_i -> valid_o drops.
- Start-bit glitch: hold rx_i low for 1 sample -> state returns to IDLE, no valid_o, no error. Then reset mid-DATA -> all outputs at reset values, and the next frame 0x3C is received correctly.
- With UART_RX_BREAK_DETECT_EN: hold rx_i low for 2 frame times, then high -> break_o = 1, err_o[0] = 0. After 1 idle bit, frame 0x12 is received normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive framer: parity modes, FSM states,
// error-flag bit positions and a 3-input majority helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int ERR_FRAME   = 0;
    localparam int ERR_PARITY  = 1;
    localparam int ERR_OVERRUN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_majority3.sv
// Sliding 3-sample window over a serial stream with a majority-vote output.
// The window is the two previous samples plus the current one.
module uart_majority3
    import uart_pkg::*;
(
    input  logic rx_sampler_clk,
    input  logic rx_sampler_reset,
    input  logic sample,
    output logic maj
);

    logic [1:0] hist_reg;

    always_ff @(posedge rx_sampler_clk or negedge rx_sampler_reset) begin
        if (!rx_sampler_reset) begin
            hist_reg <= 2'b11;
        end else begin
            hist_reg <= {hist_reg[0], sample};
        end
    end

    assign maj = maj3({hist_reg, sample});

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer clocked at OVERSAMPLE x baud with majority voting,
// valid/ready output and sticky errors. Define UART_RX_BREAK_DETECT_EN for break_o.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 3,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 rx_sampler_clk,
    input  logic                 rx_sampler_reset,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [2:0]           err_o,
    input  logic                 err_clr_i,
    output logic                 busy_o
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                 break_o
`endif
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] VOTE_CNT = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic [1:0]           sync_reg;
    logic                 rxs;
    logic                 vote;
    logic                 vote_now;
    logic                 wrap;
    logic                 stop_final;
    logic                 par_expect;
    logic                 deliver;
    logic                 frame_err;

    rx_state_t            state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [BIT_W-1:0]     bitno_reg, bitno_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] data_reg, data_next;
    logic                 par_err_reg, par_err_next;
    logic                 stop_idx_reg, stop_idx_next;
    logic                 valid_reg, valid_next;
    logic [2:0]           err_reg, err_next;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                 par_bit_reg, par_bit_next;
    logic                 brk_reg, brk_next;
    logic                 brk_evt;
`endif

    // Synchroniser idles high so reset never looks like a start bit.
    always_ff @(posedge rx_sampler_clk or negedge rx_sampler_reset) begin
        if (!rx_sampler_reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx_i};
        end
    end

    assign rxs = sync_reg[1];

    uart_majority3 u_vote (
        .rx_sampler_clk   (rx_sampler_clk),
        .rx_sampler_reset (rx_sampler_reset),
        .sample           (rxs),
        .maj              (vote)
    );

    assign vote_now   = (cnt_reg == VOTE_CNT);
    assign wrap       = (cnt_reg == LAST_CNT);
    assign stop_final = (STOP_BITS == 1) || stop_idx_reg;
    assign par_expect = (PARITY == PAR_ODD) ? ~(^shift_reg) : (^shift_reg);

    always_comb begin
        state_next    = state_reg;
        cnt_next      = wrap ? '0 : cnt_reg + 1'b1;
        bitno_next    = bitno_reg;
        shift_next    = shift_reg;
        data_next     = data_reg;
        par_err_next  = par_err_reg;
        stop_idx_next = stop_idx_reg;
        valid_next    = valid_reg;
        err_next      = err_clr_i ? 3'b000 : err_reg;
        deliver       = 1'b0;
        frame_err     = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        par_bit_next  = par_bit_reg;
        brk_next      = err_clr_i ? 1'b0 : brk_reg;
        brk_evt       = 1'b0;
`endif

        if (valid_reg && ready_i) begin
            valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!rxs) begin
                    // The detecting sample is index 0 of the start bit.
                    state_next    = START;
                    cnt_next      = CNT_W'(1);
                    par_err_next  = 1'b0;
                    stop_idx_next = 1'b0;
                end
            end
            START: begin
                if (vote_now && vote) begin
                    state_next = IDLE;
                end else if (wrap) begin
                    state_next = DATA;
                    bitno_next = '0;
                end
            end
            DATA: begin
                if (vote_now) begin
                    shift_next = {vote, shift_reg[DATA_BITS-1:1]};
                end
                if (wrap) begin
                    if (bitno_reg == LAST_BIT) begin
                        state_next = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                    end else begin
                        bitno_next = bitno_reg + 1'b1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (vote_now) begin
                    par_err_next = (vote != par_expect);
`ifdef UART_RX_BREAK_DETECT_EN
                    par_bit_next = vote;
`endif
                end
                if (wrap) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (vote_now && !vote) begin
                    state_next = IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                    if ((shift_reg == '0) && ((PARITY == PAR_NONE) || !par_bit_reg)) begin
                        state_next = BREAK;
                        cnt_next   = '0;
                        brk_evt    = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
`else
                    frame_err = 1'b1;
`endif
                end else if (vote_now && stop_final) begin
                    // Leave before the bit ends so the next start edge is not missed.
                    state_next = IDLE;
                    deliver    = 1'b1;
                end else if (wrap) begin
                    stop_idx_next = 1'b1;
                end
            end
`ifdef UART_RX_BREAK_DETECT_EN
            BREAK: begin
                // cnt counts consecutive idle-level samples here.
                if (!rxs) begin
                    cnt_next = '0;
                end else if (wrap) begin
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        if (deliver) begin
            if (!valid_reg || ready_i) begin
                data_next  = shift_reg;
                valid_next = 1'b1;
            end else begin
                err_next[ERR_OVERRUN] = 1'b1;
            end
            if (par_err_reg) begin
                err_next[ERR_PARITY] = 1'b1;
            end
        end
        if (frame_err) begin
            err_next[ERR_FRAME] = 1'b1;
        end
`ifdef UART_RX_BREAK_DETECT_EN
        if (brk_evt) begin
            brk_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge rx_sampler_clk or negedge rx_sampler_reset) begin
        if (!rx_sampler_reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bitno_reg    <= '0;
            shift_reg    <= '0;
            data_reg     <= '0;
            par_err_reg  <= 1'b0;
            stop_idx_reg <= 1'b0;
            valid_reg    <= 1'b0;
            err_reg      <= 3'b000;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_reg  <= 1'b0;
            brk_reg      <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bitno_reg    <= bitno_next;
            shift_reg    <= shift_next;
            data_reg     <= data_next;
            par_err_reg  <= par_err_next;
            stop_idx_reg <= stop_idx_next;
            valid_reg    <= valid_next;
            err_reg      <= err_next;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_reg  <= par_bit_next;
            brk_reg      <= brk_next;
`endif
        end
    end

    assign data_o  = data_reg;
    assign valid_o = valid_reg;
    assign err_o   = err_reg;
    assign busy_o  = (state_reg != IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
    assign break_o = brk_reg;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: two instances (8N1 at 3x, 7E2 at 16x) driven with
// directed and random frames, checked against a frame-level reference model.
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err_clr = 1'b0;
    logic       rx [2];
    logic       ready [2];

    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       valid_a, valid_b, busy_a, busy_b;
    logic [2:0] err_a, err_b;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       brk_a, brk_b;
`endif

    always #5 clk = ~clk;

    uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(3), .PARITY(0), .STOP_BITS(1)) dut_a (
        .rx_sampler_clk   (clk),
        .rx_sampler_reset (rst_n),
        .rx_i             (rx[0]),
        .data_o           (data_a),
        .valid_o          (valid_a),
        .ready_i          (ready[0]),
        .err_o            (err_a),
        .err_clr_i        (err_clr),
        .busy_o           (busy_a)
`ifdef UART_RX_BREAK_DETECT_EN
        ,
        .break_o          (brk_a)
`endif
    );

    uart_rx_frame #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(2)) dut_b (
        .rx_sampler_clk   (clk),
        .rx_sampler_reset (rst_n),
        .rx_i             (rx[1]),
        .data_o           (data_b),
        .valid_o          (valid_b),
        .ready_i          (ready[1]),
        .err_o            (err_b),
        .err_clr_i        (err_clr),
        .busy_o           (busy_b)
`ifdef UART_RX_BREAK_DETECT_EN
        ,
        .break_o          (brk_b)
`endif
    );

    // Reference model state per instance.
    logic       m_valid [2];
    logic [8:0] m_data [2];
    logic [2:0] m_err [2];
    logic       m_break [2];
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    int n_checks = 0;
    int n_fail = 0;

    function automatic int os_of(input int u);
        return (u == 0) ? 3 : 16;
    endfunction
    function automatic int nb_of(input int u);
        return (u == 0) ? 8 : 7;
    endfunction
    function automatic int ns_of(input int u);
        return (u == 0) ? 1 : 2;
    endfunction

    function automatic logic [8:0] obs_data(input int u);
        return (u == 0) ? {1'b0, data_a} : {2'b00, data_b};
    endfunction
    function automatic logic obs_valid(input int u);
        return (u == 0) ? valid_a : valid_b;
    endfunction
    function automatic logic [2:0] obs_err(input int u);
        return (u == 0) ? err_a : err_b;
    endfunction
    function automatic logic obs_busy(input int u);
        return (u == 0) ? busy_a : busy_b;
    endfunction

    // Accepted words, tagged with the instance number.
    always @(negedge clk) begin
        if (valid_a && ready[0]) got_q.push_back({1'b0, 1'b0, data_a});
        if (valid_b && ready[1]) got_q.push_back({1'b1, 2'b00, data_b});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        for (int u = 0; u < 2; u++) begin
            m_valid[u] = 1'b0;
            m_data[u]  = '0;
            m_err[u]   = '0;
            m_break[u] = 1'b0;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        logic [9:0] g, e;
        @(negedge clk);
        check_eq({tag, "_acc_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check_eq({tag, "_acc_word"}, g, e);
        end
        got_q.delete();
        exp_q.delete();
        for (int u = 0; u < 2; u++) begin
            check_eq($sformatf("%s_u%0d_valid", tag, u), obs_valid(u), m_valid[u]);
            check_eq($sformatf("%s_u%0d_data", tag, u), obs_data(u), m_data[u]);
            check_eq($sformatf("%s_u%0d_err", tag, u), obs_err(u), m_err[u]);
            check_eq($sformatf("%s_u%0d_busy", tag, u), obs_busy(u), 1'b0);
`ifdef UART_RX_BREAK_DETECT_EN
            check_eq($sformatf("%s_u%0d_break", tag, u), (u == 0) ? brk_a : brk_b, m_break[u]);
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input int u, input logic v);
        ready[u] = v;
        if (v && m_valid[u]) begin
            exp_q.push_back({u[0], m_data[u]});
            m_valid[u] = 1'b0;
        end
        $display("ready u%0d <= %0b", u, v);
        tick(3);
        check_state("ready");
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        for (int u = 0; u < 2; u++) begin
            m_err[u]   = '0;
            m_break[u] = 1'b0;
        end
    endtask

    task automatic send_frame(input int u, input logic [8:0] d, input bit par_bad, input bit stop_bad);
        logic [8:0] dm;
        logic       p;
        bit         bits[$];
        dm = d & 9'((1 << nb_of(u)) - 1);
        p  = (^dm) ^ par_bad;              // instance 1 uses even parity
        bits.push_back(1'b0);
        for (int i = 0; i < nb_of(u); i++) bits.push_back(dm[i]);
        if (u == 1) bits.push_back(p);
        if (stop_bad) bits.push_back(1'b0);
        else for (int i = 0; i < ns_of(u); i++) bits.push_back(1'b1);
        foreach (bits[i]) begin
            rx[u] = bits[i];
            tick(os_of(u));
        end
        rx[u] = 1'b1;
        $display("frame u%0d data=0x%03h par_bad=%0b stop_bad=%0b ready=%0b", u, dm, par_bad, stop_bad, ready[u]);

        if (stop_bad) begin
`ifdef UART_RX_BREAK_DETECT_EN
            if (dm == 0 && (u == 0 || p == 1'b0)) m_break[u] = 1'b1;
            else m_err[u][0] = 1'b1;
`else
            m_err[u][0] = 1'b1;
`endif
        end else begin
            if (u == 1 && (($countones(dm) + p) % 2) != 0) m_err[u][1] = 1'b1;
            if (!m_valid[u] || ready[u]) begin
                m_data[u] = dm;
                if (ready[u]) exp_q.push_back({u[0], dm});
                else m_valid[u] = 1'b1;
            end else begin
                m_err[u][2] = 1'b1;
            end
        end
        tick(os_of(u) * (2 + $urandom_range(0, 2)) + $urandom_range(0, 3));
        check_state("frame");
    endtask

    initial begin
        int u;
        rx[0] = 1'b1;
        rx[1] = 1'b1;
        ready[0] = 1'b1;
        ready[1] = 1'b1;
        reset_model();
        tick(4);
        check_state("reset");
        rst_n = 1'b1;
        tick(4);

        // Back-to-back words with ready held high.
        send_frame(0, 9'h55, 1'b0, 1'b0);
        send_frame(0, 9'hC3, 1'b0, 1'b0);

        // 7E2: good parity, then bad parity.
        send_frame(1, 9'h2A, 1'b0, 1'b0);
        send_frame(1, 9'h2A, 1'b1, 1'b0);
        pulse_clr();

        // Stop bit low, then clear.
        send_frame(0, 9'hFF, 1'b0, 1'b1);
        pulse_clr();
        check_state("clr");

        // Overrun with the consumer stalled.
        set_ready(0, 1'b0);
        send_frame(0, 9'h81, 1'b0, 1'b0);
        send_frame(0, 9'hA5, 1'b0, 1'b0);
        set_ready(0, 1'b1);
        pulse_clr();

        for (int k = 0; k < 36; k++) begin
            u = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) set_ready(u, !ready[u]);
            if ($urandom_range(0, 4) == 0) pulse_clr();
            send_frame(u, 9'($urandom_range(0, 511)), (u == 1) && ($urandom_range(0, 3) == 0),
                       $urandom_range(0, 6) == 0);
        end
        set_ready(0, 1'b1);
        set_ready(1, 1'b1);

        // One-sample start glitch on each line.
        for (int g = 0; g < 2; g++) begin
            rx[g] = 1'b0;
            tick(1);
            rx[g] = 1'b1;
            $display("glitch u%0d", g);
            tick(os_of(g) * 3);
            check_state("glitch");
        end

        // Reset in the middle of the data bits.
        rx[0] = 1'b0;
        tick(3);
        rx[0] = 1'b0;
        tick(3);
        rx[0] = 1'b1;
        tick(3);
        @(negedge clk);
        check_eq("busy_mid_frame", obs_busy(0), 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        reset_model();
        $display("reset mid-frame");
        check_state("mid_reset");
        rx[0] = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        send_frame(0, 9'h3C, 1'b0, 1'b0);

`ifdef UART_RX_BREAK_DETECT_EN
        for (int b = 0; b < 2; b++) begin
            rx[b] = 1'b0;
            tick(2 * os_of(b) * (1 + nb_of(b) + b + ns_of(b)));
            rx[b] = 1'b1;
            tick(os_of(b));
            m_break[b] = 1'b1;
            $display("break u%0d", b);
            send_frame(b, 9'h12, 1'b0, 1'b0);
            pulse_clr();
            check_state("break_clr");
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
